i2c_slv_byte_ctl: RTL

Byte-level protocol engine for one I2C slave channel. Consumes the bit-level event stream (`i2c_start`, `i2c_spc_stop`, `i2c_strobe`, `i2c_mst_data`) produced by the slave PHY, and returns the bit to drive on SDA through `i2c_slv_data`. It decodes the 7-bit device address, a register pointer and data bytes, and drives a simple register-file port. One instance sits beside each slave PHY instance (a and b).

---
 rtl/i2c_slv_byte_ctl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/i2c_slv_byte_ctl.sv
// Byte-level protocol engine for one I2C slave channel.
// Turns the PHY's START/STOP/strobe events into address, pointer and data
// bytes, drives the ACK / read-data bit back to SDA, and runs a simple
// register-file port (reg_addr / reg_wr / reg_rd).
//
// Handshake with the register file: reg_wr is a one-cycle pulse with
// reg_addr/reg_wdata valid in the same cycle; reg_rd is a one-cycle pulse
// with reg_addr valid, and reg_rdata must be valid exactly one cycle later.
module i2c_slv_byte_ctl #(
  parameter logic [6:0] SLV_ADDR = 7'h50
) (
  input  logic       ck_ref,
  input  logic       rst_ref,
  input  logic       i2c_start,
  input  logic       i2c_spc_stop,
  input  logic       i2c_strobe,
  input  logic       i2c_mst_data,
  output logic       i2c_slv_data,
  output logic [7:0] reg_addr,
  output logic       reg_wr,
  output logic [7:0] reg_wdata,
  output logic       reg_rd,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic [3:0] dbg_state
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    ADDR_ACK  = 4'd2,
    PTR       = 4'd3,
    PTR_ACK   = 4'd4,
    WDATA     = 4'd5,
    WDATA_ACK = 4'd6,
    RDATA     = 4'd7,
    RDATA_ACK = 4'd8,
    IGNORE    = 4'd9
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  bit_cnt;
  logic [6:0]  sh_q;        // 7 bits suffice: the 8th bit is taken live
  logic        rw_q;
  logic        rd_pend;     // reg_rd was high last cycle -> reg_rdata valid now
  logic [7:0]  rx_byte;

  logic        sda_d;
  logic        cnt_clr, cnt_inc;
  logic        shift_in, shift_out, rd_cap;
  logic        rw_ld, ptr_ld, wr_go, rd_go, addr_inc;

  assign rx_byte   = {sh_q, i2c_mst_data};
  assign busy      = (state_q != IDLE) && (state_q != IGNORE);
  assign dbg_state = state_q;

  // State register.
  always_ff @(posedge ck_ref or negedge rst_ref) begin
    if (!rst_ref) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state and datapath controls; STOP outranks START, both outrank a strobe.
  always_comb begin
    state_d   = state_q;
    sda_d     = i2c_slv_data;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    shift_in  = 1'b0;
    shift_out = 1'b0;
    rd_cap    = 1'b0;
    rw_ld     = 1'b0;
    ptr_ld    = 1'b0;
    wr_go     = 1'b0;
    rd_go     = 1'b0;
    addr_inc  = 1'b0;
    if (i2c_spc_stop) begin
      state_d = IDLE;
      sda_d   = 1'b1;
      cnt_clr = 1'b1;
    end else if (i2c_start) begin
      state_d = ADDR;
      sda_d   = 1'b1;
      cnt_clr = 1'b1;
    end else if (i2c_strobe) begin
      case (state_q)
        ADDR: begin
          cnt_inc  = 1'b1;
          shift_in = 1'b1;
          if (bit_cnt == 3'd7) begin
            if (sh_q == SLV_ADDR) begin
              rw_ld   = 1'b1;
              state_d = ADDR_ACK;
              sda_d   = 1'b0;
            end else begin
              state_d = IGNORE;
              sda_d   = 1'b1;
            end
          end
        end
        ADDR_ACK: begin
          sda_d = 1'b1;
          if (rw_q) begin
            rd_go   = 1'b1;
            state_d = RDATA;
          end else begin
            state_d = PTR;
          end
        end
        PTR: begin
          cnt_inc  = 1'b1;
          shift_in = 1'b1;
          if (bit_cnt == 3'd7) begin
            ptr_ld  = 1'b1;
            state_d = PTR_ACK;
            sda_d   = 1'b0;
          end
        end
        PTR_ACK: begin
          state_d = WDATA;
          sda_d   = 1'b1;
        end
        WDATA: begin
          cnt_inc  = 1'b1;
          shift_in = 1'b1;
          if (bit_cnt == 3'd7) begin
            wr_go   = 1'b1;
            state_d = WDATA_ACK;
            sda_d   = 1'b0;
          end
        end
        WDATA_ACK: begin
          addr_inc = 1'b1;
          state_d  = WDATA;
          sda_d    = 1'b1;
        end
        RDATA: begin
          cnt_inc   = 1'b1;
          shift_out = 1'b1;
          if (bit_cnt == 3'd7) begin
            state_d = RDATA_ACK;
            sda_d   = 1'b1;
          end else begin
            sda_d   = sh_q[6];
          end
        end
        RDATA_ACK: begin
          addr_inc = 1'b1;
          sda_d    = 1'b1;
          if (!i2c_mst_data) begin
            rd_go   = 1'b1;
            state_d = RDATA;
          end else begin
            state_d = IGNORE;
          end
        end
        default: begin
          sda_d = 1'b1;
        end
      endcase
    end else if (rd_pend && (state_q == RDATA)) begin
      rd_cap = 1'b1;
      sda_d  = reg_rdata[7];
    end
  end

  // Datapath registers: bit counter, shifter, pointer, write data and pulses.
  always_ff @(posedge ck_ref or negedge rst_ref) begin
    if (!rst_ref) begin
      i2c_slv_data <= 1'b1;
      bit_cnt      <= 3'd0;
      sh_q         <= 7'd0;
      rw_q         <= 1'b0;
      rd_pend      <= 1'b0;
      reg_addr     <= 8'd0;
      reg_wdata    <= 8'd0;
      reg_wr       <= 1'b0;
      reg_rd       <= 1'b0;
    end else begin
      i2c_slv_data <= sda_d;
      reg_wr       <= wr_go;
      reg_rd       <= rd_go;
      rd_pend      <= reg_rd;
      if (cnt_clr)      bit_cnt <= 3'd0;
      else if (cnt_inc) bit_cnt <= bit_cnt + 3'd1;
      if (shift_in)       sh_q <= {sh_q[5:0], i2c_mst_data};
      else if (shift_out) sh_q <= {sh_q[5:0], 1'b0};
      else if (rd_cap)    sh_q <= reg_rdata[6:0];
      if (rw_ld) rw_q <= i2c_mst_data;
      if (ptr_ld)        reg_addr <= rx_byte;
      else if (addr_inc) reg_addr <= reg_addr + 8'd1;
      if (wr_go) reg_wdata <= rx_byte;
    end
  end

endmodule
